// File: rtl/m_serial_sched.sv
// m_serial_sched: round-robin arbiter and sequencer for one shared bit-serial adder.
// Defining SERIAL_SUB_EN makes op=1 perform rs-rt; without it every op is an add.
module m_serial_sched #(
  parameter int WIDTH = 32,
  parameter int CNTW = 6
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_req0,
  input  logic [WIDTH-1:0] w_rs0,
  input  logic [WIDTH-1:0] w_rt0,
  input  logic             w_op0,
  input  logic             w_req1,
  input  logic [WIDTH-1:0] w_rs1,
  input  logic [WIDTH-1:0] w_rt1,
  input  logic             w_op1,
  output logic             w_gnt0,
  output logic             w_gnt1,
  output logic             w_busy,
  output logic             w_vld,
  output logic             w_id,
  output logic [WIDTH-1:0] w_rslt,
  output logic             w_cout
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, rt_sel;
  logic [CNTW-1:0] cnt;
  logic [1:0] sum;
  logic carry, rr, win, pick, any_req, last, sub;
  assign any_req = w_req0 | w_req1;
  assign pick = (w_req0 & w_req1) ? rr : w_req1;
  assign rt_sel = pick ? w_rt1 : w_rt0;
  assign sum = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, carry};
  // each sum bit enters at the MSB, so after WIDTH shifts A holds the result
  assign a_nxt = {sum[0], a[WIDTH-1:1]};
  assign last = cnt == CNTW'(WIDTH - 1);
`ifdef SERIAL_SUB_EN
  assign sub = pick ? w_op1 : w_op0;
`else
  logic unused_op;
  assign unused_op = w_op0 ^ w_op1;
  assign sub = 1'b0;
`endif
  always_ff @(posedge w_clk)
    state <= w_rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (any_req ? RUN : IDLE) :
                (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  // grant is the first RUN cycle, so it lasts exactly one cycle after acceptance
  always_comb begin
    w_busy = state != IDLE;
    w_vld  = state == DONE;
    w_gnt0 = (state == RUN) && (cnt == '0) && !win;
    w_gnt1 = (state == RUN) && (cnt == '0) && win;
  end
  always_ff @(posedge w_clk)
    if (w_rst) begin
      a      <= '0;
      b      <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      rr     <= 1'b0;
      win    <= 1'b0;
      w_id   <= 1'b0;
      w_rslt <= '0;
      w_cout <= 1'b0;
    end else if (state == IDLE && any_req) begin
      a     <= pick ? w_rs1 : w_rs0;
      b     <= sub ? ~rt_sel : rt_sel;
      carry <= sub;
      cnt   <= '0;
      rr    <= ~pick;
      win   <= pick;
    end else if (state == RUN) begin
      a     <= a_nxt;
      b     <= {1'b0, b[WIDTH-1:1]};
      carry <= sum[1];
      cnt   <= cnt + 1'b1;
      if (last) begin
        w_rslt <= a_nxt;
        w_cout <= sum[1];
        w_id   <= win;
      end
    end
endmodule

// File: tb/tb_m_serial_sched.sv
// tb_m_serial_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_m_serial_sched;
  localparam int W = 32;
  logic w_clk = 1'b0;
  logic w_rst, w_req0, w_op0, w_req1, w_op1;
  logic [W-1:0] w_rs0, w_rt0, w_rs1, w_rt1;
  logic w_gnt0, w_gnt1, w_busy, w_vld, w_id, w_cout;
  logic [W-1:0] w_rslt;
  int n_chk = 0, n_fail = 0, cyc = 0;
  // model: ph counts cycles since acceptance (0 = idle, 1 = grant cycle, W+1 = result cycle)
  int ph = 0;
  logic m_rr = 1'b0, m_win = 1'b0, m_id = 1'b0, m_cout = 1'b0, p_cout = 1'b0;
  logic [W-1:0] m_rslt = '0, p_rslt = '0;

  m_serial_sched #(.WIDTH(W), .CNTW(6)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_req0(w_req0), .w_rs0(w_rs0), .w_rt0(w_rt0), .w_op0(w_op0),
    .w_req1(w_req1), .w_rs1(w_rs1), .w_rt1(w_rt1), .w_op1(w_op1),
    .w_gnt0(w_gnt0), .w_gnt1(w_gnt1), .w_busy(w_busy), .w_vld(w_vld),
    .w_id(w_id), .w_rslt(w_rslt), .w_cout(w_cout)
  );

  always #5 w_clk = ~w_clk;

  task automatic model_edge();
    logic [W-1:0] rs, rt;
    if (w_rst) begin
      ph = 0; m_rr = 1'b0; m_win = 1'b0; m_id = 1'b0; m_rslt = '0; m_cout = 1'b0;
    end else if (ph == 0) begin
      if (w_req0 || w_req1) begin
        m_win = (w_req0 && w_req1) ? m_rr : w_req1;
        rs = m_win ? w_rs1 : w_rs0;
        rt = m_win ? w_rt1 : w_rt0;
        {p_cout, p_rslt} = {1'b0, rs} + {1'b0, rt};
`ifdef SERIAL_SUB_EN
        if (m_win ? w_op1 : w_op0) begin
          p_rslt = rs - rt;
          p_cout = rs >= rt;
        end
`endif
        m_rr = !m_win;
        ph = 1;
      end
    end else if (ph == W + 1) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == W + 1) begin
        m_rslt = p_rslt; m_cout = p_cout; m_id = m_win;
      end
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    model_edge();
    cyc++;
    @(negedge w_clk);
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!w_vld && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic who, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       input logic op, output int n);
    int k = 0;
    if (who) begin
      w_req1 = 1'b1; w_rs1 = rs; w_rt1 = rt; w_op1 = op;
    end else begin
      w_req0 = 1'b1; w_rs0 = rs; w_rt0 = rt; w_op0 = op;
    end
    while (!(who ? w_gnt1 : w_gnt0) && k < 60) begin
      tick();
      k++;
    end
    w_req0 = 1'b0;
    w_req1 = 1'b0;
    if (k >= 60) n = 100;
    else wait_vld(n);
  endtask

  function automatic logic [W-1:0] rnd();
    int s = $urandom_range(0, 5);
    return (s == 0) ? '0 : (s == 1) ? '1 : (s == 2) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
  endfunction

  task automatic test_reset();
    w_rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1, w_busy, w_vld, w_id, w_cout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got gnt0,gnt1,busy,vld,id,cout=%b want 000000",
               {w_gnt0, w_gnt1, w_busy, w_vld, w_id, w_cout});
    end
    n_chk++;
    if (w_rslt !== '0) begin
      n_fail++;
      $display("FAIL reset_rslt got %h want 0", w_rslt);
    end
    w_rst = 1'b0;
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1, w_busy} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_no_req got gnt0,gnt1,busy=%b want 000", {w_gnt0, w_gnt1, w_busy});
    end
  endtask

  task automatic test_single();
    int n;
    w_req0 = 1'b1; w_rs0 = 6; w_rt0 = 7; w_op0 = 1'b0;
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1, w_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_gnt got gnt0,gnt1,busy=%b want 101", {w_gnt0, w_gnt1, w_busy});
    end
    w_req0 = 1'b0;
    wait_vld(n);
    n_chk++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL single_latency got %0d want %0d", n, W);
    end
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b0, 1'b0, 32'd13}) begin
      n_fail++;
      $display("FAIL single_rslt got id=%b cout=%b rslt=%0d want id=0 cout=0 rslt=13", w_id, w_cout, w_rslt);
    end
    tick();
    n_chk++;
    if ({w_vld, w_busy, w_rslt} !== {2'b00, 32'd13}) begin
      n_fail++;
      $display("FAIL single_hold got vld=%b busy=%b rslt=%0d want vld=0 busy=0 rslt=13", w_vld, w_busy, w_rslt);
    end
  endtask

  task automatic test_both();
    int n, tg, k;
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    w_req0 = 1'b1; w_rs0 = 6; w_rt0 = 7; w_op0 = 1'b0;
    w_req1 = 1'b1; w_rs1 = 1; w_rt1 = 2; w_op1 = 1'b0;
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_first_gnt got gnt0,gnt1=%b want 10", {w_gnt0, w_gnt1});
    end
    tg = cyc;
    w_req0 = 1'b0;
    wait_vld(n);
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b0, 1'b0, 32'd13}) begin
      n_fail++;
      $display("FAIL both_first_rslt got id=%b cout=%b rslt=%0d want id=0 cout=0 rslt=13", w_id, w_cout, w_rslt);
    end
    k = 0;
    while (!w_gnt1 && k < 5) begin
      tick();
      k++;
    end
    n_chk++;
    if (!w_gnt1 || cyc - tg != W + 2) begin
      n_fail++;
      $display("FAIL both_second_gnt got gnt1=%b gap=%0d want gnt1=1 gap=%0d", w_gnt1, cyc - tg, W + 2);
    end
    w_req1 = 1'b0;
    wait_vld(n);
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b1, 1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL both_second_rslt got id=%b cout=%b rslt=%0d want id=1 cout=0 rslt=3", w_id, w_cout, w_rslt);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta[2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb[2] = '{32'h1, 32'h8000_0000};
    int n;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, ta[i], tb[i], 1'b0, n);
      n_chk++;
      if (n != W || w_rslt !== '0 || w_cout !== 1'b1) begin
        n_fail++;
        $display("FAIL carry_%0d got lat=%0d rslt=%h cout=%b want lat=%0d rslt=0 cout=1", i, n, w_rslt, w_cout, W);
      end
    end
  endtask

  task automatic test_sub();
    int n;
    issue(1'b0, 32'd7, 32'd6, 1'b1, n);
`ifdef SERIAL_SUB_EN
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL sub_7m6 got id=%b cout=%b rslt=%h want id=0 cout=1 rslt=1", w_id, w_cout, w_rslt);
    end
    issue(1'b1, 32'd6, 32'd7, 1'b1, n);
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL sub_6m7 got id=%b cout=%b rslt=%h want id=1 cout=0 rslt=ffffffff", w_id, w_cout, w_rslt);
    end
`else
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b0, 1'b0, 32'd13}) begin
      n_fail++;
      $display("FAIL op_ignored0 got id=%b cout=%b rslt=%0d want id=0 cout=0 rslt=13", w_id, w_cout, w_rslt);
    end
    issue(1'b1, 32'd6, 32'd7, 1'b1, n);
    n_chk++;
    if ({w_id, w_cout, w_rslt} !== {1'b1, 1'b0, 32'd13}) begin
      n_fail++;
      $display("FAIL op_ignored1 got id=%b cout=%b rslt=%0d want id=1 cout=0 rslt=13", w_id, w_cout, w_rslt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int v = 0;
    w_req0 = 1'b1; w_rs0 = 32'd5; w_rt0 = 32'd9; w_op0 = 1'b0;
    tick();
    w_req0 = 1'b0;
    repeat (10) tick();
    w_rst = 1'b1;
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1, w_vld, w_busy, w_id, w_cout, w_rslt} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset got gnt0=%b gnt1=%b vld=%b busy=%b id=%b cout=%b rslt=%h want all 0",
               w_gnt0, w_gnt1, w_vld, w_busy, w_id, w_cout, w_rslt);
    end
    w_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      v += int'(w_vld | w_busy);
    end
    n_chk++;
    if (v != 0) begin
      n_fail++;
      $display("FAIL abort_no_vld got %0d active cycles want 0", v);
    end
  endtask

  task automatic test_mid_req();
    int n, tg, k, g;
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    w_req0 = 1'b1; w_rs0 = 1; w_rt0 = 1; w_op0 = 1'b0;
    tick();
    n_chk++;
    if ({w_gnt0, w_gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_first_gnt got gnt0,gnt1=%b want 10", {w_gnt0, w_gnt1});
    end
    tg = cyc;
    w_req0 = 1'b0;
    repeat (5) tick();
    w_req0 = 1'b1; w_rs0 = 3; w_rt0 = 4;
    w_req1 = 1'b1; w_rs1 = 10; w_rt1 = 20; w_op1 = 1'b0;
    g = 0;
    k = 0;
    while (w_busy && k < 60) begin
      g += int'(w_gnt0 | w_gnt1);
      tick();
      k++;
    end
    n_chk++;
    if (g != 0) begin
      n_fail++;
      $display("FAIL mid_gnt_while_busy got %0d grants want 0", g);
    end
    k = 0;
    while (!w_gnt0 && !w_gnt1 && k < 5) begin
      tick();
      k++;
    end
    n_chk++;
    if ({w_gnt0, w_gnt1} !== 2'b01 || cyc - tg != W + 2) begin
      n_fail++;
      $display("FAIL mid_rr_gnt1 got gnt0,gnt1=%b gap=%0d want 01 gap=%0d", {w_gnt0, w_gnt1}, cyc - tg, W + 2);
    end
    tg = cyc;
    w_req1 = 1'b0;
    wait_vld(n);
    n_chk++;
    if ({w_id, w_rslt} !== {1'b1, 32'd30}) begin
      n_fail++;
      $display("FAIL mid_rslt1 got id=%b rslt=%0d want id=1 rslt=30", w_id, w_rslt);
    end
    k = 0;
    while (!w_gnt0 && k < 5) begin
      tick();
      k++;
    end
    n_chk++;
    if (!w_gnt0 || cyc - tg != W + 2) begin
      n_fail++;
      $display("FAIL mid_held_gnt0 got gnt0=%b gap=%0d want gnt0=1 gap=%0d", w_gnt0, cyc - tg, W + 2);
    end
    w_req0 = 1'b0;
    wait_vld(n);
    n_chk++;
    if ({w_id, w_rslt} !== {1'b0, 32'd7}) begin
      n_fail++;
      $display("FAIL mid_rslt0 got id=%b rslt=%0d want id=0 rslt=7", w_id, w_rslt);
    end
  endtask

  task automatic test_random();
    logic [W+5:0] exp, got;
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      exp = {ph == 1 && !m_win, ph == 1 && m_win, ph != 0, ph == W + 1, m_id, m_cout, m_rslt};
      got = {w_gnt0, w_gnt1, w_busy, w_vld, w_id, w_cout, w_rslt};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cyc%0d got gnt0,gnt1,busy,vld,id,cout=%b rslt=%h want %b rslt=%h",
                 i, got[W+5:W], got[W-1:0], exp[W+5:W], exp[W-1:0]);
      end
      w_rst = $urandom_range(0, 299) == 0;
      if (w_gnt0 || !w_req0) begin
        w_req0 = $urandom_range(0, 2) == 0;
        w_rs0 = rnd(); w_rt0 = rnd(); w_op0 = 1'($urandom);
      end else if ($urandom_range(0, 39) == 0) begin
        w_req0 = 1'b0;
      end
      if (w_gnt1 || !w_req1) begin
        w_req1 = $urandom_range(0, 2) == 0;
        w_rs1 = rnd(); w_rt1 = rnd(); w_op1 = 1'($urandom);
      end else if ($urandom_range(0, 39) == 0) begin
        w_req1 = 1'b0;
      end
      tick();
    end
    w_req0 = 1'b0;
    w_req1 = 1'b0;
    w_rst = 1'b0;
  endtask

  initial begin
    w_rst = 1'b1;
    w_req0 = 1'b0; w_req1 = 1'b0; w_op0 = 1'b0; w_op1 = 1'b0;
    w_rs0 = '0; w_rt0 = '0; w_rs1 = '0; w_rt1 = '0;
    test_reset();
    test_single();
    test_both();
    test_carry();
    test_sub();
    test_reset_mid();
    test_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
